// File: rtl/multicore_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicore_pkg
//  Description : Shared types and constants for the 5-stage core hazard logic.
//                Holds the hazard FSM state type, the forwarding-select type,
//                the write-back source encodings and the register count.
//  Revision    : 2.0 - second-generation hazard controller
// ============================================================================
package multicore_pkg;

    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        LOAD_STALL = 2'd2,
        FLUSH      = 2'd3
    } hazard_state_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MA   = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_e;

    // Write-back source encodings carried by the *_memtoreg fields
    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;
    localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

endpackage : multicore_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Bundle between the pipeline and the hazard controller.
//                i_* fields: stage status from decode/execute/MA/WB.
//                o_* fields: redirect, stage enables, stage flushes,
//                forwarding selects and performance counters.
//                master = pipeline side, slave = hazard controller.
//  Revision    : 2.0 - second-generation hazard controller
// ============================================================================
interface hazard_ctrl_if #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = multicore_pkg::NUM_REGS
);
    import multicore_pkg::*;

    localparam int RW = $clog2(NUM_REGS);

    // Pipeline status
    logic            i_decode_br_valid;
    logic [XLEN-1:0] i_decode_br_addr;
    logic [XLEN-1:0] i_decode_pc;
    logic [RW-1:0]   i_decode_rs1;
    logic [RW-1:0]   i_decode_rs2;
    logic            i_execute_br_valid;
    logic [XLEN-1:0] i_execute_br_addr;
    logic [RW-1:0]   i_exe_rs1;
    logic [RW-1:0]   i_exe_rs2;
    logic [RW-1:0]   i_exe_rdest;
    logic            i_exe_regwrite;
    logic [1:0]      i_exe_memtoreg;
    logic [RW-1:0]   i_ma_rdest;
    logic            i_ma_regwrite;
    logic [1:0]      i_ma_memtoreg;
    logic            i_ma_memaccess;
    logic            i_ma_cache_ready;
    logic [RW-1:0]   i_wb_rdest;
    logic            i_wb_regwrite;

    // Controller outputs
    logic            o_br_valid;
    logic [XLEN-1:0] o_br_addr;
    logic            o_fetch_en;
    logic            o_decode_en;
    logic            o_exe_en;
    logic            o_ma_en;
    logic            o_decode_flush;
    logic            o_exe_flush;
    fwd_sel_e        o_decode_fwd_a;
    fwd_sel_e        o_decode_fwd_b;
    fwd_sel_e        o_exe_fwd_a;
    fwd_sel_e        o_exe_fwd_b;
    logic [31:0]     o_stall_cycles;
    logic [31:0]     o_flush_events;

    modport master (
        output i_decode_br_valid, i_decode_br_addr, i_decode_pc,
               i_decode_rs1, i_decode_rs2,
               i_execute_br_valid, i_execute_br_addr,
               i_exe_rs1, i_exe_rs2, i_exe_rdest, i_exe_regwrite, i_exe_memtoreg,
               i_ma_rdest, i_ma_regwrite, i_ma_memtoreg, i_ma_memaccess,
               i_ma_cache_ready, i_wb_rdest, i_wb_regwrite,
        input  o_br_valid, o_br_addr, o_fetch_en, o_decode_en, o_exe_en, o_ma_en,
               o_decode_flush, o_exe_flush,
               o_decode_fwd_a, o_decode_fwd_b, o_exe_fwd_a, o_exe_fwd_b,
               o_stall_cycles, o_flush_events
    );

    modport slave (
        input  i_decode_br_valid, i_decode_br_addr, i_decode_pc,
               i_decode_rs1, i_decode_rs2,
               i_execute_br_valid, i_execute_br_addr,
               i_exe_rs1, i_exe_rs2, i_exe_rdest, i_exe_regwrite, i_exe_memtoreg,
               i_ma_rdest, i_ma_regwrite, i_ma_memtoreg, i_ma_memaccess,
               i_ma_cache_ready, i_wb_rdest, i_wb_regwrite,
        output o_br_valid, o_br_addr, o_fetch_en, o_decode_en, o_exe_en, o_ma_en,
               o_decode_flush, o_exe_flush,
               o_decode_fwd_a, o_decode_fwd_b, o_exe_fwd_a, o_exe_fwd_b,
               o_stall_cycles, o_flush_events
    );

endinterface : hazard_ctrl_if
`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fwd_sel
//  Description : Forwarding select for one source operand (combinational).
//                MA wins over WB; an MA load result is not yet available so
//                it never forwards from MA; x0 never forwards.
//  Ports       : i_rs                     source register
//                i_ma_rdest/regwrite/memtoreg  MA producer
//                i_wb_rdest/regwrite           WB producer
//                o_sel                    FWD_NONE / FWD_MA / FWD_WB
//  Revision    : 2.0 - second-generation hazard controller
// ============================================================================
module hazard_fwd_sel
    import multicore_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic [RW-1:0] i_rs,
    input  logic [RW-1:0] i_ma_rdest,
    input  logic          i_ma_regwrite,
    input  logic [1:0]    i_ma_memtoreg,
    input  logic [RW-1:0] i_wb_rdest,
    input  logic          i_wb_regwrite,
    output fwd_sel_e      o_sel
);

    logic w_ma_hit;
    logic w_wb_hit;

    assign w_ma_hit = i_ma_regwrite && (i_ma_rdest == i_rs) &&
                      ((i_ma_memtoreg == MEMTOREG_ALU) || (i_ma_memtoreg == MEMTOREG_PC4));
    assign w_wb_hit = i_wb_regwrite && (i_wb_rdest == i_rs);

    always_comb begin
        o_sel = FWD_NONE;
        if (i_rs != '0) begin
            if (w_ma_hit) begin
                o_sel = FWD_MA;
            end else if (w_wb_hit) begin
                o_sel = FWD_WB;
            end
        end
    end

endmodule : hazard_fwd_sel
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller for the 5-stage core. Drives the
//                stage enables, stage flushes, fetch redirect and the four
//                operand forwarding selects. A sequencing FSM handles
//                load-use stalls, data-cache wait freezes and multi-cycle
//                mispredict flushes.
//  Ports       : i_aclk       clock
//                i_areset_n   asynchronous reset, active low; while low all
//                             outputs are forced to their idle values
//                hz_if        hazard_ctrl_if.slave (status in, controls out)
//  Config      : HAZARD_PERF_CNT_EN - when defined, o_stall_cycles and
//                o_flush_events are live saturating counters; otherwise both
//                read as zero and no counter flops exist.
//  Revision    : 2.0 - second-generation hazard controller
// ============================================================================
module hazard_ctrl #(
    parameter int XLEN              = 32,
    parameter int NUM_REGS          = multicore_pkg::NUM_REGS,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1
) (
    input  logic         i_aclk,
    input  logic         i_areset_n,
    hazard_ctrl_if.slave hz_if
);
    import multicore_pkg::*;

    localparam int RW = $clog2(NUM_REGS);

    // Counter preload: the detection cycle is the first bubble/flush cycle
    localparam logic [3:0] c_LS_INIT = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [3:0] c_FL_INIT = 4'(FLUSH_CYCLES - 1);

    // ------------------------------------------------------------------
    // Forwarding selects: decode a/b, execute a/b
    // ------------------------------------------------------------------
    logic [RW-1:0] w_fwd_rs  [4];
    fwd_sel_e      w_fwd_sel [4];

    assign w_fwd_rs[0] = hz_if.i_decode_rs1;
    assign w_fwd_rs[1] = hz_if.i_decode_rs2;
    assign w_fwd_rs[2] = hz_if.i_exe_rs1;
    assign w_fwd_rs[3] = hz_if.i_exe_rs2;

    for (genvar g = 0; g < 4; g++) begin : g_fwd
        hazard_fwd_sel #(.RW(RW)) u_fwd_sel (
            .i_rs          (w_fwd_rs[g]),
            .i_ma_rdest    (hz_if.i_ma_rdest),
            .i_ma_regwrite (hz_if.i_ma_regwrite),
            .i_ma_memtoreg (hz_if.i_ma_memtoreg),
            .i_wb_rdest    (hz_if.i_wb_rdest),
            .i_wb_regwrite (hz_if.i_wb_regwrite),
            .o_sel         (w_fwd_sel[g])
        );
    end

    // ------------------------------------------------------------------
    // Hazard events
    // ------------------------------------------------------------------
    logic w_mem_wait;
    logic w_mispredict;
    logic w_load_use;

    assign w_mem_wait   = hz_if.i_ma_memaccess & ~hz_if.i_ma_cache_ready;
    assign w_mispredict = hz_if.i_execute_br_valid &
                          (hz_if.i_decode_pc != hz_if.i_execute_br_addr);
    assign w_load_use   = hz_if.i_exe_regwrite &&
                          (hz_if.i_exe_memtoreg == MEMTOREG_MEM) &&
                          (hz_if.i_exe_rdest != '0) &&
                          ((hz_if.i_exe_rdest == hz_if.i_decode_rs1) ||
                           (hz_if.i_exe_rdest == hz_if.i_decode_rs2));

    // ------------------------------------------------------------------
    // FSM. r_ret remembers which state a cache wait interrupted so that a
    // partly-counted stall or flush resumes with its counter intact.
    // ------------------------------------------------------------------
    hazard_state_e r_state, w_state_nxt;
    hazard_state_e r_ret,   w_ret_nxt;
    logic [3:0]    r_cnt,   w_cnt_nxt;

    logic w_frozen;
    logic w_fetch_en, w_decode_en, w_exe_en, w_ma_en;
    logic w_br_valid, w_decode_flush, w_exe_flush;

    // The freeze is combinational on the wait itself so the pipeline never
    // advances past a cache miss, and lasts one extra cycle (registered
    // MEM_WAIT) while the returning data is captured.
    assign w_frozen = (r_state == MEM_WAIT) | w_mem_wait;

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state <= RUN;
            r_ret   <= RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ret   <= w_ret_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ret_nxt      = r_ret;
        w_cnt_nxt      = r_cnt;
        w_fetch_en     = 1'b1;
        w_decode_en    = 1'b1;
        w_exe_en       = 1'b1;
        w_ma_en        = 1'b1;
        w_br_valid     = 1'b0;
        w_decode_flush = 1'b0;
        w_exe_flush    = 1'b0;

        if (w_frozen) begin
            w_fetch_en  = 1'b0;
            w_decode_en = 1'b0;
            w_exe_en    = 1'b0;
            w_ma_en     = 1'b0;
            if (r_state != MEM_WAIT) begin
                w_ret_nxt = r_state;
            end
            w_state_nxt = w_mem_wait ? MEM_WAIT : r_ret;
        end else begin
            case (r_state)
                RUN: begin
                    w_br_valid     = hz_if.i_execute_br_valid | hz_if.i_decode_br_valid;
                    w_decode_flush = hz_if.i_decode_br_valid & ~w_mispredict;
                    if (w_mispredict) begin
                        w_decode_flush = 1'b1;
                        w_exe_flush    = 1'b1;
                        w_cnt_nxt      = c_FL_INIT;
                        w_state_nxt    = (c_FL_INIT != 4'd0) ? FLUSH : RUN;
                    end else if (w_load_use) begin
                        w_fetch_en  = 1'b0;
                        w_decode_en = 1'b0;
                        w_exe_flush = 1'b1;
                        w_cnt_nxt   = c_LS_INIT;
                        w_state_nxt = (c_LS_INIT != 4'd0) ? LOAD_STALL : RUN;
                    end
                end

                LOAD_STALL: begin
                    if (w_mispredict) begin
                        // Wrong-path instructions make the stall moot
                        w_br_valid     = 1'b1;
                        w_decode_flush = 1'b1;
                        w_exe_flush    = 1'b1;
                        w_cnt_nxt      = c_FL_INIT;
                        w_state_nxt    = (c_FL_INIT != 4'd0) ? FLUSH : RUN;
                    end else begin
                        w_fetch_en  = 1'b0;
                        w_decode_en = 1'b0;
                        w_exe_flush = 1'b1;
                        if (r_cnt <= 4'd1) begin
                            w_cnt_nxt   = 4'd0;
                            w_state_nxt = RUN;
                        end else begin
                            w_cnt_nxt = r_cnt - 4'd1;
                        end
                    end
                end

                FLUSH: begin
                    w_decode_flush = 1'b1;
                    w_exe_flush    = 1'b1;
                    if (r_cnt <= 4'd1) begin
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end

                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs, forced idle while reset is asserted
    // ------------------------------------------------------------------
    assign hz_if.o_fetch_en     = i_areset_n & w_fetch_en;
    assign hz_if.o_decode_en    = i_areset_n & w_decode_en;
    assign hz_if.o_exe_en       = i_areset_n & w_exe_en;
    assign hz_if.o_ma_en        = i_areset_n & w_ma_en;
    assign hz_if.o_br_valid     = i_areset_n & w_br_valid;
    assign hz_if.o_decode_flush = i_areset_n & w_decode_flush;
    assign hz_if.o_exe_flush    = i_areset_n & w_exe_flush;
    assign hz_if.o_br_addr      = !i_areset_n ? '0 :
                                  hz_if.i_execute_br_valid ? hz_if.i_execute_br_addr
                                                           : hz_if.i_decode_br_addr;
    assign hz_if.o_decode_fwd_a = i_areset_n ? w_fwd_sel[0] : FWD_NONE;
    assign hz_if.o_decode_fwd_b = i_areset_n ? w_fwd_sel[1] : FWD_NONE;
    assign hz_if.o_exe_fwd_a    = i_areset_n ? w_fwd_sel[2] : FWD_NONE;
    assign hz_if.o_exe_fwd_b    = i_areset_n ? w_fwd_sel[3] : FWD_NONE;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic        w_stall_inc;
    logic        w_flush_inc;
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    // Load-use detection counts only when it actually wins arbitration
    assign w_stall_inc = w_frozen | (r_state == LOAD_STALL) |
                         ((r_state == RUN) & w_load_use & ~w_mispredict);
    assign w_flush_inc = ~w_frozen & w_mispredict &
                         ((r_state == RUN) | (r_state == LOAD_STALL));

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_stall_cycles <= 32'd0;
            r_flush_events <= 32'd0;
        end else begin
            if (w_stall_inc && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_flush_inc && (r_flush_events != 32'hFFFF_FFFF)) begin
                r_flush_events <= r_flush_events + 32'd1;
            end
        end
    end

    assign hz_if.o_stall_cycles = r_stall_cycles;
    assign hz_if.o_flush_events = r_flush_events;
`else
    assign hz_if.o_stall_cycles = 32'd0;
    assign hz_if.o_flush_events = 32'd0;
`endif

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl (LOAD_STALL_CYCLES=2,
//                FLUSH_CYCLES=3). Reference model tracks remaining bubbles,
//                remaining flush cycles and whether the cache was waiting
//                last cycle.
//  Revision    : 2.0 - second-generation hazard controller
// ============================================================================
module tb_hazard_ctrl;

    localparam int L = 2;
    localparam int F = 3;

    logic clk;
    logic rst_n;

    hazard_ctrl_if #(.XLEN(32), .NUM_REGS(32)) hz ();

    hazard_ctrl #(
        .XLEN(32), .NUM_REGS(32), .LOAD_STALL_CYCLES(L), .FLUSH_CYCLES(F)
    ) dut (
        .i_aclk     (clk),
        .i_areset_n (rst_n),
        .hz_if      (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_stall_left;
    int          m_flush_left;
    logic        m_mw_prev;
    int unsigned m_stall_cnt;
    int unsigned m_flush_cnt;

    // Expected outputs
    logic        e_bv, e_fe, e_de, e_ee, e_me, e_dfl, e_efl;
    logic [31:0] e_ba;
    logic [1:0]  e_fwd [4];

    typedef struct {
        logic [4:0] rs;
        logic [4:0] ma_rd;
        logic       ma_rw;
        logic [1:0] ma_m2r;
        logic [4:0] wb_rd;
        logic       wb_rw;
        logic [1:0] exp_sel;
    } fwd_vec_t;

    fwd_vec_t fwd_tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] f_fwd(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (hz.i_ma_regwrite && hz.i_ma_rdest == rs &&
            (hz.i_ma_memtoreg == 2'b00 || hz.i_ma_memtoreg == 2'b10)) return 2'b01;
        if (hz.i_wb_regwrite && hz.i_wb_rdest == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        hz.i_decode_br_valid  = 0; hz.i_decode_br_addr  = 0; hz.i_decode_pc = 0;
        hz.i_decode_rs1       = 0; hz.i_decode_rs2      = 0;
        hz.i_execute_br_valid = 0; hz.i_execute_br_addr = 0;
        hz.i_exe_rs1 = 0; hz.i_exe_rs2 = 0; hz.i_exe_rdest = 0;
        hz.i_exe_regwrite = 0; hz.i_exe_memtoreg = 0;
        hz.i_ma_rdest = 0; hz.i_ma_regwrite = 0; hz.i_ma_memtoreg = 0;
        hz.i_ma_memaccess = 0; hz.i_ma_cache_ready = 1;
        hz.i_wb_rdest = 0; hz.i_wb_regwrite = 0;
    endtask

    // Settle, predict this cycle's outputs, compare, advance the model
    task automatic eval_check();
        logic mw, mp, lu, si, fi;
        #3;
        mw = hz.i_ma_memaccess & ~hz.i_ma_cache_ready;
        mp = hz.i_execute_br_valid && (hz.i_decode_pc != hz.i_execute_br_addr);
        lu = hz.i_exe_regwrite && hz.i_exe_memtoreg == 2'b01 && hz.i_exe_rdest != 0 &&
             (hz.i_exe_rdest == hz.i_decode_rs1 || hz.i_exe_rdest == hz.i_decode_rs2);
        si = 0; fi = 0;
        if (!rst_n) begin
            e_bv = 0; e_ba = 0; e_fe = 0; e_de = 0; e_ee = 0; e_me = 0; e_dfl = 0; e_efl = 0;
            for (int i = 0; i < 4; i++) e_fwd[i] = 2'b00;
            m_stall_left = 0; m_flush_left = 0; m_mw_prev = 0;
            m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            e_fe = 1; e_de = 1; e_ee = 1; e_me = 1; e_bv = 0; e_dfl = 0; e_efl = 0;
            e_ba = hz.i_execute_br_valid ? hz.i_execute_br_addr : hz.i_decode_br_addr;
            e_fwd[0] = f_fwd(hz.i_decode_rs1);
            e_fwd[1] = f_fwd(hz.i_decode_rs2);
            e_fwd[2] = f_fwd(hz.i_exe_rs1);
            e_fwd[3] = f_fwd(hz.i_exe_rs2);
            if (mw || m_mw_prev) begin
                e_fe = 0; e_de = 0; e_ee = 0; e_me = 0;
                si = 1;
            end else if (m_flush_left > 0) begin
                e_dfl = 1; e_efl = 1;
                m_flush_left--;
            end else if (m_stall_left > 0) begin
                si = 1;
                if (mp) begin
                    e_bv = 1; e_dfl = 1; e_efl = 1; fi = 1;
                    m_stall_left = 0; m_flush_left = F - 1;
                end else begin
                    e_fe = 0; e_de = 0; e_efl = 1;
                    m_stall_left--;
                end
            end else begin
                e_bv  = hz.i_execute_br_valid | hz.i_decode_br_valid;
                e_dfl = hz.i_decode_br_valid & ~mp;
                if (mp) begin
                    e_dfl = 1; e_efl = 1; fi = 1;
                    m_flush_left = F - 1;
                end else if (lu) begin
                    e_fe = 0; e_de = 0; e_efl = 1; si = 1;
                    m_stall_left = L - 1;
                end
            end
        end
        chk("br_valid",     hz.o_br_valid,     e_bv);
        chk("br_addr",      hz.o_br_addr,      e_ba);
        chk("fetch_en",     hz.o_fetch_en,     e_fe);
        chk("decode_en",    hz.o_decode_en,    e_de);
        chk("exe_en",       hz.o_exe_en,       e_ee);
        chk("ma_en",        hz.o_ma_en,        e_me);
        chk("decode_flush", hz.o_decode_flush, e_dfl);
        chk("exe_flush",    hz.o_exe_flush,    e_efl);
        chk("decode_fwd_a", hz.o_decode_fwd_a, e_fwd[0]);
        chk("decode_fwd_b", hz.o_decode_fwd_b, e_fwd[1]);
        chk("exe_fwd_a",    hz.o_exe_fwd_a,    e_fwd[2]);
        chk("exe_fwd_b",    hz.o_exe_fwd_b,    e_fwd[3]);
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cycles", hz.o_stall_cycles, m_stall_cnt);
        chk("flush_events", hz.o_flush_events, m_flush_cnt);
`else
        chk("stall_cycles", hz.o_stall_cycles, 32'd0);
        chk("flush_events", hz.o_flush_events, 32'd0);
`endif
        if (rst_n) begin
            m_stall_cnt += 32'(si);
            m_flush_cnt += 32'(fi);
            m_mw_prev = mw;
        end
    endtask

    task automatic chk_perf(input string name, input int unsigned stall_exp, input int unsigned flush_exp);
`ifdef HAZARD_PERF_CNT_EN
        chk({name, "_stall"}, hz.o_stall_cycles, stall_exp);
        chk({name, "_flush"}, hz.o_flush_events, flush_exp);
`else
        chk({name, "_stall"}, hz.o_stall_cycles, 32'd0 & stall_exp);
        chk({name, "_flush"}, hz.o_flush_events, 32'd0 & flush_exp);
`endif
    endtask

    initial begin
        fwd_tbl[0] = '{5'd5,  5'd5, 1'b1, 2'b00, 5'd5,  1'b1, 2'b01};
        fwd_tbl[1] = '{5'd0,  5'd0, 1'b1, 2'b00, 5'd0,  1'b1, 2'b00};
        fwd_tbl[2] = '{5'd5,  5'd5, 1'b1, 2'b01, 5'd5,  1'b1, 2'b10};
        fwd_tbl[3] = '{5'd5,  5'd5, 1'b1, 2'b10, 5'd3,  1'b1, 2'b01};
        fwd_tbl[4] = '{5'd5,  5'd5, 1'b0, 2'b00, 5'd5,  1'b1, 2'b10};
        fwd_tbl[5] = '{5'd5,  5'd6, 1'b1, 2'b00, 5'd5,  1'b0, 2'b00};
        fwd_tbl[6] = '{5'd9,  5'd9, 1'b1, 2'b11, 5'd4,  1'b1, 2'b00};
        fwd_tbl[7] = '{5'd31, 5'd2, 1'b1, 2'b00, 5'd31, 1'b1, 2'b10};

        rst_n = 0;
        quiet();
        tick();
        eval_check();                       // reset state
        tick();
        eval_check();
        rst_n = 1;
        tick();
        eval_check();                       // first cycle after release
        chk("post_reset_fetch_en", hz.o_fetch_en, 1'b1);

        // ---------------- forwarding table ----------------
        for (int i = 0; i < 8; i++) begin
            hz.i_decode_rs1  = fwd_tbl[i].rs; hz.i_decode_rs2 = fwd_tbl[i].rs;
            hz.i_exe_rs1     = fwd_tbl[i].rs; hz.i_exe_rs2    = fwd_tbl[i].rs;
            hz.i_ma_rdest    = fwd_tbl[i].ma_rd;
            hz.i_ma_regwrite = fwd_tbl[i].ma_rw;
            hz.i_ma_memtoreg = fwd_tbl[i].ma_m2r;
            hz.i_wb_rdest    = fwd_tbl[i].wb_rd;
            hz.i_wb_regwrite = fwd_tbl[i].wb_rw;
            eval_check();
            chk($sformatf("fwd_tbl%0d_dec_a", i), hz.o_decode_fwd_a, fwd_tbl[i].exp_sel);
            chk($sformatf("fwd_tbl%0d_exe_b", i), hz.o_exe_fwd_b,    fwd_tbl[i].exp_sel);
            tick();
        end
        quiet();

        // ---------------- load-use, 2 bubbles ----------------
        hz.i_exe_regwrite = 1; hz.i_exe_memtoreg = 2'b01; hz.i_exe_rdest = 5'd7;
        hz.i_decode_rs2 = 5'd7;
        eval_check();
        chk("ld_c0_fetch_en",  hz.o_fetch_en,  1'b0);
        chk("ld_c0_decode_en", hz.o_decode_en, 1'b0);
        chk("ld_c0_exe_flush", hz.o_exe_flush, 1'b1);
        tick();
        quiet();
        eval_check();
        chk("ld_c1_fetch_en",  hz.o_fetch_en,  1'b0);
        chk("ld_c1_exe_flush", hz.o_exe_flush, 1'b1);
        tick();
        eval_check();
        chk("ld_c2_fetch_en",  hz.o_fetch_en,  1'b1);
        chk("ld_c2_exe_flush", hz.o_exe_flush, 1'b0);
        chk_perf("ld_done", 2, 0);
        tick();

        // ---------------- mispredict, 3 flush cycles ----------------
        hz.i_execute_br_valid = 1; hz.i_execute_br_addr = 32'h100; hz.i_decode_pc = 32'h104;
        eval_check();
        chk("mp_c0_br_valid", hz.o_br_valid,     1'b1);
        chk("mp_c0_br_addr",  hz.o_br_addr,      32'h100);
        chk("mp_c0_dflush",   hz.o_decode_flush, 1'b1);
        chk("mp_c0_eflush",   hz.o_exe_flush,    1'b1);
        tick();
        quiet();
        for (int c = 1; c <= 2; c++) begin
            eval_check();
            chk($sformatf("mp_c%0d_dflush", c), hz.o_decode_flush, 1'b1);
            chk($sformatf("mp_c%0d_eflush", c), hz.o_exe_flush,    1'b1);
            chk($sformatf("mp_c%0d_br", c),     hz.o_br_valid,     1'b0);
            tick();
        end
        eval_check();
        chk("mp_c3_dflush", hz.o_decode_flush, 1'b0);
        chk_perf("mp_done", 2, 1);
        tick();

        // ---------------- correctly predicted branch ----------------
        hz.i_execute_br_valid = 1; hz.i_execute_br_addr = 32'h100; hz.i_decode_pc = 32'h100;
        eval_check();
        chk("ok_br_valid", hz.o_br_valid,     1'b1);
        chk("ok_dflush",   hz.o_decode_flush, 1'b0);
        chk("ok_eflush",   hz.o_exe_flush,    1'b0);
        chk("ok_fetch_en", hz.o_fetch_en,     1'b1);
        tick();
        quiet();
        eval_check();
        chk("ok_next_eflush", hz.o_exe_flush, 1'b0);
        tick();

        // ---------------- cache wait inside a load stall ----------------
        hz.i_exe_regwrite = 1; hz.i_exe_memtoreg = 2'b01; hz.i_exe_rdest = 5'd7;
        hz.i_decode_rs1 = 5'd7;
        eval_check();                       // detection
        tick();
        quiet();
        hz.i_ma_memaccess = 1; hz.i_ma_cache_ready = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) hz.i_ma_cache_ready = 1;
            eval_check();
            chk($sformatf("mw_c%0d_fetch_en", c), hz.o_fetch_en, 1'b0);
            chk($sformatf("mw_c%0d_ma_en", c),    hz.o_ma_en,    1'b0);
            tick();
        end
        quiet();
        eval_check();
        chk("mw_rem_fetch_en",  hz.o_fetch_en,  1'b0);
        chk("mw_rem_exe_flush", hz.o_exe_flush, 1'b1);
        chk("mw_rem_exe_en",    hz.o_exe_en,    1'b1);
        tick();
        eval_check();
        chk("mw_run_fetch_en", hz.o_fetch_en, 1'b1);
        chk_perf("mw_done", 8, 1);
        tick();

        // ---------------- reset in the middle of a flush ----------------
        hz.i_execute_br_valid = 1; hz.i_execute_br_addr = 32'h200; hz.i_decode_pc = 32'h204;
        eval_check();
        tick();
        quiet();
        eval_check();
        chk("rf_pre_dflush", hz.o_decode_flush, 1'b1);
        #1;
        hz.i_decode_rs1 = 5'd5; hz.i_ma_rdest = 5'd5; hz.i_ma_regwrite = 1;
        hz.i_decode_br_addr = 32'h44;
        rst_n = 0;
        #1;
        chk("rf_rst_dflush",   hz.o_decode_flush, 1'b0);
        chk("rf_rst_fetch_en", hz.o_fetch_en,     1'b0);
        chk("rf_rst_br_addr",  hz.o_br_addr,      32'h0);
        chk("rf_rst_fwd_a",    hz.o_decode_fwd_a, 2'b00);
        tick();
        eval_check();
        tick();
        rst_n = 1;
        quiet();
        eval_check();
        chk("rf_rel_fetch_en", hz.o_fetch_en,     1'b1);
        chk("rf_rel_dflush",   hz.o_decode_flush, 1'b0);
        chk_perf("rf_rel", 0, 0);
        tick();

        // ---------------- randomized run against the model ----------------
        for (int n = 0; n < 3000; n++) begin
            rst_n                 = ($urandom_range(0, 149) != 0);
            hz.i_decode_br_valid  = ($urandom_range(0, 4) == 0);
            hz.i_decode_br_addr   = 32'($urandom_range(0, 7)) << 2;
            hz.i_decode_pc        = 32'($urandom_range(0, 3)) << 2;
            hz.i_execute_br_valid = ($urandom_range(0, 4) == 0);
            hz.i_execute_br_addr  = 32'($urandom_range(0, 3)) << 2;
            hz.i_decode_rs1       = 5'($urandom_range(0, 3));
            hz.i_decode_rs2       = 5'($urandom_range(0, 3));
            hz.i_exe_rs1          = 5'($urandom_range(0, 3));
            hz.i_exe_rs2          = 5'($urandom_range(0, 3));
            hz.i_exe_rdest        = 5'($urandom_range(0, 3));
            hz.i_exe_regwrite     = 1'($urandom_range(0, 1));
            hz.i_exe_memtoreg     = 2'($urandom_range(0, 3));
            hz.i_ma_rdest         = 5'($urandom_range(0, 3));
            hz.i_ma_regwrite      = 1'($urandom_range(0, 1));
            hz.i_ma_memtoreg      = 2'($urandom_range(0, 3));
            hz.i_ma_memaccess     = ($urandom_range(0, 9) < 3);
            hz.i_ma_cache_ready   = ($urandom_range(0, 9) < 6);
            hz.i_wb_rdest         = 5'($urandom_range(0, 3));
            hz.i_wb_regwrite      = 1'($urandom_range(0, 1));
            eval_check();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
